// File: rtl/regfile_multiport_dbg_if.sv
// Write, read and debug-dump signal bundle for regfile_multiport_dbg.
// master = pipeline/debug side driving the register file, slave = register file.
interface regfile_multiport_dbg_if #(
   parameter int WIDTH_B = 32,
   parameter int ADDR_B  = 5,
   parameter int NUM_RD  = 2
);
   logic                       RegWrite;
   logic [ADDR_B-1:0]          Write_Addr;
   logic [WIDTH_B-1:0]         Write_Data;
   logic [NUM_RD*ADDR_B-1:0]   Read_Addr;
   logic [NUM_RD*WIDTH_B-1:0]  Read_Data;
   logic                       dbg_start;
   logic                       dbg_ready;
   logic                       dbg_valid;
   logic [ADDR_B-1:0]          dbg_addr;
   logic [WIDTH_B-1:0]         dbg_data;
   logic                       dbg_busy;
   logic                       dbg_done;

   modport master (
      output RegWrite, Write_Addr, Write_Data, Read_Addr, dbg_start, dbg_ready,
      input  Read_Data, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
   );

   modport slave (
      input  RegWrite, Write_Addr, Write_Data, Read_Addr, dbg_start, dbg_ready,
      output Read_Data, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
   );
endinterface

// File: rtl/regfile_multiport_dbg.sv
// Multi-read-port register file with optional hardwired r0 and a debug dump streamer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_multiport_dbg #(
   parameter int WIDTH_B  = 32,
   parameter int ADDR_B   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_multiport_dbg_if.slave bus
);
   localparam int                DEPTH     = 2 ** ADDR_B;
   localparam logic [ADDR_B-1:0] LAST_ADDR = ADDR_B'(DEPTH - 1);
   localparam logic [ADDR_B-1:0] ADDR_ZERO = ADDR_B'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } dump_state_t;

   logic [WIDTH_B-1:0]        regs_r [DEPTH];
   dump_state_t               state_r;
   dump_state_t               state_nx_s;
   logic [ADDR_B-1:0]         dbg_addr_r;
   logic [ADDR_B-1:0]         dbg_addr_nx_s;
   logic                      dbg_valid_r;
   logic                      dbg_busy_r;
   logic                      dbg_done_r;
   logic                      wr_en_s;
   logic [NUM_RD*WIDTH_B-1:0] rd_data_s;

   function automatic logic is_r0(input logic [ADDR_B-1:0] addr);
      return (ZERO_REG == 1) && (addr == ADDR_ZERO);
   endfunction

   assign wr_en_s = bus.RegWrite && !is_r0(bus.Write_Addr);

   // Register storage: whole array cleared on reset, one write port otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wr_en_s) begin
         regs_r[bus.Write_Addr] <= bus.Write_Data;
      end
   end

   // Combinational read ports, each fully independent of the others
   always_comb begin
      rd_data_s = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (is_r0(bus.Read_Addr[k*ADDR_B +: ADDR_B])) begin
            rd_data_s[k*WIDTH_B +: WIDTH_B] = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (!reset && wr_en_s &&
                      (bus.Read_Addr[k*ADDR_B +: ADDR_B] == bus.Write_Addr)) begin
            rd_data_s[k*WIDTH_B +: WIDTH_B] = bus.Write_Data;
`endif
         end else begin
            rd_data_s[k*WIDTH_B +: WIDTH_B] = regs_r[bus.Read_Addr[k*ADDR_B +: ADDR_B]];
         end
      end
   end

   assign bus.Read_Data = rd_data_s;

   // Dump FSM next state: walks addresses 0..DEPTH-1, holding on back-pressure
   always_comb begin
      state_nx_s    = state_r;
      dbg_addr_nx_s = dbg_addr_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.dbg_start) begin
               state_nx_s    = ST_SEND;
               dbg_addr_nx_s = ADDR_ZERO;
            end else begin
               state_nx_s    = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (bus.dbg_ready) begin
               if (dbg_addr_r == LAST_ADDR) begin
                  state_nx_s    = ST_DONE;
               end else begin
                  dbg_addr_nx_s = dbg_addr_r + ADDR_B'(1);
               end
            end else begin
               dbg_addr_nx_s = dbg_addr_r;
            end
         end
         ST_DONE: begin
            state_nx_s    = ST_IDLE;
            dbg_addr_nx_s = ADDR_ZERO;
         end
         default: begin
            state_nx_s    = ST_IDLE;
            dbg_addr_nx_s = ADDR_ZERO;
         end
      endcase
   end

   // Dump FSM state, address and status flags; reset aborts any dump silently
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         dbg_addr_r  <= ADDR_ZERO;
         dbg_valid_r <= 1'b0;
         dbg_busy_r  <= 1'b0;
         dbg_done_r  <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         dbg_addr_r  <= dbg_addr_nx_s;
         dbg_valid_r <= (state_nx_s == ST_SEND);
         dbg_busy_r  <= (state_nx_s == ST_SEND);
         dbg_done_r  <= (state_nx_s == ST_DONE);
      end
   end

   assign bus.dbg_valid = dbg_valid_r;
   assign bus.dbg_busy  = dbg_busy_r;
   assign bus.dbg_done  = dbg_done_r;
   assign bus.dbg_addr  = dbg_addr_r;
   // Live register contents, deliberately without write forwarding
   assign bus.dbg_data  = is_r0(dbg_addr_r) ? '0 : regs_r[dbg_addr_r];
endmodule

// File: tb/tb_regfile_multiport_dbg.sv
// Randomized self-checking bench for regfile_multiport_dbg against an array-based model.
module tb_regfile_multiport_dbg;
   localparam int WIDTH_B = 32;
   localparam int ADDR_B  = 5;
   localparam int NUM_RD  = 2;
   localparam int DEPTH   = 32;

   logic clk = 1'b0;
   logic reset;

   regfile_multiport_dbg_if #(.WIDTH_B(WIDTH_B), .ADDR_B(ADDR_B), .NUM_RD(NUM_RD)) bus ();

   regfile_multiport_dbg #(
      .WIDTH_B (WIDTH_B),
      .ADDR_B  (ADDR_B),
      .NUM_RD  (NUM_RD),
      .ZERO_REG(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [31:0] mreg [DEPTH];
   logic        m_busy;
   logic        m_done;
   logic [4:0]  m_idx;
   logic [36:0] beats [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : mreg[a];
   endfunction

   function automatic logic [31:0] m_port(input logic [4:0] a);
      logic [31:0] v;
      v = m_read(a);
`ifdef REGFILE_BYPASS_EN
      if (!reset && bus.RegWrite && (a == bus.Write_Addr) && (a != 5'd0)) v = bus.Write_Data;
`endif
      return v;
   endfunction

   // Reference model: storage array plus "dump in progress / next index / done pulse"
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mreg[i] <= 32'h0;
         m_busy <= 1'b0;
         m_idx  <= 5'd0;
         m_done <= 1'b0;
      end else begin
         if (bus.RegWrite && bus.Write_Addr != 5'd0) mreg[bus.Write_Addr] <= bus.Write_Data;
         m_done <= m_busy && bus.dbg_ready && (m_idx == 5'd31);
         if (m_busy) begin
            if (bus.dbg_ready) begin
               m_idx <= m_idx + 5'd1;
               if (m_idx == 5'd31) m_busy <= 1'b0;
            end
         end else if (!m_done && bus.dbg_start) begin
            m_busy <= 1'b1;
            m_idx  <= 5'd0;
         end
         if (bus.dbg_valid && bus.dbg_ready) beats.push_back({bus.dbg_addr, bus.dbg_data});
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("rd%0d", k), 64'(bus.Read_Data[k*32 +: 32]),
                  64'(m_port(bus.Read_Addr[k*5 +: 5])));
         end
         check("dbg_valid", 64'(bus.dbg_valid), 64'(m_busy));
         check("dbg_busy", 64'(bus.dbg_busy), 64'(m_busy));
         check("dbg_done", 64'(bus.dbg_done), 64'(m_done));
         if (m_busy) begin
            check("dbg_addr", 64'(bus.dbg_addr), 64'(m_idx));
            check("dbg_data", 64'(bus.dbg_data), 64'(m_read(m_idx)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_all_zero(input string name);
      for (int a = 0; a < DEPTH; a++) begin
         bus.Read_Addr = {5'(31 - a), 5'(a)};
         #1;
         check({name, "_p0"}, 64'(bus.Read_Data[31:0]), 64'h0);
         check({name, "_p1"}, 64'(bus.Read_Data[63:32]), 64'h0);
         tick();
      end
   endtask

   initial begin
      int          done_cyc;
      int          done_cnt;
      bit          wrote;
      bit          done_seen;
      bit          found;
      bit          pat [4];
      logic [31:0] exp_d;

      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      reset = 1'b1;
      bus.RegWrite = 1'b0; bus.Write_Addr = 5'd0; bus.Write_Data = 32'h0;
      bus.Read_Addr = 10'd0; bus.dbg_start = 1'b0; bus.dbg_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk_en = 1'b1;

      // 1: reset state
      check("rst_valid", 64'(bus.dbg_valid), 64'h0);
      check("rst_busy", 64'(bus.dbg_busy), 64'h0);
      check("rst_done", 64'(bus.dbg_done), 64'h0);
      check("rst_addr", 64'(bus.dbg_addr), 64'h0);
      read_all_zero("rst_rd");

      // 2: plain write/read and r0 discard
      bus.RegWrite = 1'b1; bus.Write_Addr = 5'd5; bus.Write_Data = 32'hDEADBEEF;
      tick();
      bus.RegWrite = 1'b0; bus.Read_Addr = {5'd5, 5'd5};
      #1;
      check("r5_p0", 64'(bus.Read_Data[31:0]), 64'hDEADBEEF);
      check("r5_p1", 64'(bus.Read_Data[63:32]), 64'hDEADBEEF);
      bus.RegWrite = 1'b1; bus.Write_Addr = 5'd0; bus.Write_Data = 32'h1234;
      tick();
      bus.RegWrite = 1'b0; bus.Read_Addr = {5'd0, 5'd0};
      #1;
      check("r0_zero", 64'(bus.Read_Data[31:0]), 64'h0);

      // 3: read-during-write on the same address
      bus.RegWrite = 1'b1; bus.Write_Addr = 5'd7; bus.Write_Data = 32'hA5A5A5A5;
      bus.Read_Addr = {5'd0, 5'd7};
      #1;
`ifdef REGFILE_BYPASS_EN
      check("rdw_same", 64'(bus.Read_Data[31:0]), 64'hA5A5A5A5);
`else
      check("rdw_same", 64'(bus.Read_Data[31:0]), 64'h0);
`endif
      tick();
      bus.RegWrite = 1'b0;
      #1;
      check("rdw_after", 64'(bus.Read_Data[31:0]), 64'hA5A5A5A5);

      // 4: full-speed dump of rN = N+100
      for (int n = 1; n < DEPTH; n++) begin
         bus.RegWrite = 1'b1; bus.Write_Addr = 5'(n); bus.Write_Data = 32'(n + 100);
         tick();
      end
      bus.RegWrite = 1'b0;
      bus.dbg_ready = 1'b1;
      beats.delete();
      bus.dbg_start = 1'b1;
      done_cyc = 0; done_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         bus.dbg_start = 1'b0;
         if (bus.dbg_done) begin
            done_cnt++;
            done_cyc = n;
         end
      end
      check("d4_done_cyc", 64'(done_cyc), 64'd33);
      check("d4_done_cnt", 64'(done_cnt), 64'd1);
      check("d4_idle", 64'(bus.dbg_busy), 64'h0);
      check("d4_nbeats", 64'(beats.size()), 64'd32);
      for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
         exp_d = (i == 0) ? 32'h0 : 32'(i + 100);
         check($sformatf("d4_beat%0d", i), 64'(beats[i]), 64'({5'(i), exp_d}));
      end

      // 5: back-pressured dump with a write to a stalled beat and an ignored restart
      beats.delete();
      bus.dbg_start = 1'b1;
      tick();
      bus.dbg_start = 1'b0;
      wrote = 1'b0; done_seen = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         bus.dbg_ready = pat[c % 4];
         bus.dbg_start = (c == 5);
         if (!wrote && bus.dbg_valid && bus.dbg_addr == 5'd3) begin
            bus.dbg_ready = 1'b0;
            bus.RegWrite = 1'b1; bus.Write_Addr = 5'd3; bus.Write_Data = 32'h55;
            wrote = 1'b1;
         end else begin
            bus.RegWrite = 1'b0;
         end
         tick();
         if (bus.dbg_done) done_seen = 1'b1;
      end
      bus.RegWrite = 1'b0; bus.dbg_start = 1'b0;
      check("d5_done", 64'(done_seen), 64'h1);
      check("d5_wrote", 64'(wrote), 64'h1);
      check("d5_nbeats", 64'(beats.size()), 64'd32);
      for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
         exp_d = (i == 0) ? 32'h0 : (i == 3) ? 32'h55 : 32'(i + 100);
         check($sformatf("d5_beat%0d", i), 64'(beats[i]), 64'({5'(i), exp_d}));
      end

      // Random traffic on every input
      for (int c = 0; c < 400; c++) begin
         bus.RegWrite   = 1'($urandom_range(0, 1));
         bus.Write_Addr = 5'($urandom);
         bus.Write_Data = $urandom;
         bus.Read_Addr  = 10'($urandom);
         if ($urandom_range(0, 3) == 0) bus.Read_Addr[4:0] = bus.Write_Addr;
         bus.dbg_start  = ($urandom_range(0, 15) == 0);
         bus.dbg_ready  = 1'($urandom_range(0, 1));
         tick();
      end

      // 6: reset in the middle of a dump
      bus.RegWrite = 1'b0; bus.dbg_start = 1'b0; bus.dbg_ready = 1'b1;
      for (int c = 0; c < 100 && (bus.dbg_busy || bus.dbg_done); c++) tick();
      bus.dbg_start = 1'b1;
      tick();
      bus.dbg_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (bus.dbg_valid && bus.dbg_addr == 5'd10) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("d6_reach10", 64'(found), 64'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("d6_valid", 64'(bus.dbg_valid), 64'h0);
      check("d6_busy", 64'(bus.dbg_busy), 64'h0);
      check("d6_addr", 64'(bus.dbg_addr), 64'h0);
      for (int c = 0; c < 5; c++) begin
         check("d6_nodone", 64'(bus.dbg_done), 64'h0);
         tick();
      end
      read_all_zero("d6_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
